// File: rtl/mmio_serial_pkg.sv
// -----------------------------------------------------------------------------
// mmio_serial_pkg: register map, STATUS/CTRL bit positions, TX state encoding
// Rev 1.0 | CTRL loopback bit is only honoured when SERIAL_LOOPBACK_EN is defined
// -----------------------------------------------------------------------------
`default_nettype none

package mmio_serial_pkg;

  localparam logic [3:0] REG_RX_COUNT  = 4'h0;
  localparam logic [3:0] REG_RX_POP    = 4'h1;
  localparam logic [3:0] REG_RX_DATA   = 4'h2;
  localparam logic [3:0] REG_TX_COUNT  = 4'h4;
  localparam logic [3:0] REG_TX_FREE   = 4'h5;
  localparam logic [3:0] REG_TX_PUSH16 = 4'h6;
  localparam logic [3:0] REG_TX_PUSH8  = 4'h7;
  localparam logic [3:0] REG_STATUS    = 4'h8;
  localparam logic [3:0] REG_CTRL      = 4'h9;

  localparam int ST_RX_OVF      = 0;
  localparam int ST_TX_OVF      = 1;
  localparam int ST_TX_BUSY     = 2;
  localparam int ST_RX_NONEMPTY = 3;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_LOOPBACK  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/mmio_serial_ctrl_channel.sv
// -----------------------------------------------------------------------------
// serial_channel: one channel - TX/RX bit FIFOs, TX line FSM, RX decoder, regs
// Rev 1.0 | SERIAL_LOOPBACK_EN adds CTRL.loopback (RX taps own TX line)
// -----------------------------------------------------------------------------
`default_nettype none

module serial_channel
  import mmio_serial_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int BIT_CLKS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        ser_in,
  output logic        ser_out,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(BIT_CLKS) + 1;
  localparam int Q  = BIT_CLKS / 4;

  logic [DEPTH-1:0] tx_mem, rx_mem;
  logic [PW-1:0]    tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0]    tx_count, rx_count;
  logic             tx_en, rx_en, rx_ovf, tx_ovf;
`ifdef SERIAL_LOOPBACK_EN
  logic             loopback;
`endif

  logic wr_pop, wr_p16, wr_p8, wr_status, wr_ctrl;
  assign wr_pop    = we && (reg_addr == REG_RX_POP);
  assign wr_p16    = we && (reg_addr == REG_TX_PUSH16);
  assign wr_p8     = we && (reg_addr == REG_TX_PUSH8);
  assign wr_status = we && (reg_addr == REG_STATUS);
  assign wr_ctrl   = we && (reg_addr == REG_CTRL);

  // Both push widths are left-aligned so bit 15 is always the first bit out.
  logic [CW-1:0] tx_free, push_len;
  logic [15:0]   push_bits;
  logic          push_req, push_ok, tx_pop;
  assign push_req  = wr_p16 || wr_p8;
  assign push_len  = wr_p16 ? CW'(16) : CW'(8);
  assign push_bits = wr_p16 ? wdata : {wdata[7:0], 8'h00};
  assign tx_free   = CW'(DEPTH) - tx_count;
  assign push_ok   = push_req && (push_len <= tx_free);

  tx_state_t     state, state_nxt;
  logic [WW-1:0] cnt, cnt_nxt;
  logic          line_nxt, cur_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ser_out <= 1'b0;
      cur_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ser_out <= line_nxt;
      if (tx_pop) cur_bit <= tx_mem[tx_rd];
    end
  end

  // IDLE occupies the last clock of each bit period, so back-to-back bits rise BIT_CLKS apart.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    line_nxt  = ser_out;
    tx_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && (tx_count != '0)) begin
          tx_pop    = 1'b1;
          line_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HEAD;
        end
      end
      HEAD: begin
        cnt_nxt = cnt + WW'(1);
        if (cnt == WW'(Q - 1)) begin
          line_nxt  = cur_bit;
          state_nxt = BODY;
        end
      end
      BODY: begin
        cnt_nxt = cnt + WW'(1);
        if (cnt == WW'(3 * Q - 1)) begin
          line_nxt  = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        cnt_nxt = cnt + WW'(1);
        if (cnt == WW'(BIT_CLKS - 2)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic          rx_src, sync1, sync2, sync_prev;
  logic [WW-1:0] width;
`ifdef SERIAL_LOOPBACK_EN
  assign rx_src = loopback ? ser_out : ser_in;
`else
  assign rx_src = ser_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      width     <= '0;
    end else begin
      sync1     <= rx_src;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (!sync2)                       width <= '0;
      else if (width != WW'(BIT_CLKS))  width <= width + WW'(1);
    end
  end

  logic          rx_fall, rx_bit, append_req, append_ok, rx_full;
  logic [15:0]   pop_req16, cnt16, pop16;
  logic [CW-1:0] pop_n, rx_after_pop;
  assign rx_fall      = sync_prev && !sync2;
  assign rx_bit       = (width >= WW'(BIT_CLKS / 2));
  assign append_req   = rx_fall && (width >= WW'(2)) && rx_en;
  assign pop_req16    = wr_pop ? {11'd0, wdata[4:0]} : 16'd0;
  assign cnt16        = 16'(rx_count);
  assign pop16        = (pop_req16 < cnt16) ? pop_req16 : cnt16;
  assign pop_n        = pop16[CW-1:0];
  assign rx_after_pop = rx_count - pop_n;
  assign rx_full      = (rx_after_pop == CW'(DEPTH));
  assign append_ok    = append_req && !rx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
      tx_en    <= 1'b1;
      rx_en    <= 1'b1;
`ifdef SERIAL_LOOPBACK_EN
      loopback <= 1'b0;
`endif
    end else begin
      if (push_ok)   tx_wr <= tx_wr + push_len[PW-1:0];
      if (tx_pop)    tx_rd <= tx_rd + PW'(1);
      tx_count <= tx_count + (push_ok ? push_len : '0) - CW'(tx_pop);
      rx_rd    <= rx_rd + pop_n[PW-1:0];
      if (append_ok) rx_wr <= rx_wr + PW'(1);
      rx_count <= rx_after_pop + CW'(append_ok);
      rx_ovf   <= (append_req && rx_full) || (rx_ovf && !(wr_status && wdata[ST_RX_OVF]));
      tx_ovf   <= (push_req && !push_ok)  || (tx_ovf && !(wr_status && wdata[ST_TX_OVF]));
      if (wr_ctrl) begin
        tx_en    <= wdata[CTRL_TX_EN];
        rx_en    <= wdata[CTRL_RX_EN];
`ifdef SERIAL_LOOPBACK_EN
        loopback <= wdata[CTRL_LOOPBACK];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int i = 0; i < 16; i++) begin
        if (i < int'(push_len)) tx_mem[tx_wr + PW'(i)] <= push_bits[15 - i];
      end
    end
    if (append_ok) rx_mem[rx_wr] <= rx_bit;
  end

  logic [15:0] rx_data, status, ctrl_rd;
  always_comb begin
    rx_data = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(rx_count)) rx_data[15 - i] = rx_mem[rx_rd + PW'(i)];
    end
  end

  always_comb begin
    status                 = '0;
    status[ST_RX_OVF]      = rx_ovf;
    status[ST_TX_OVF]      = tx_ovf;
    status[ST_TX_BUSY]     = (state != IDLE);
    status[ST_RX_NONEMPTY] = (rx_count != '0);
    ctrl_rd                = '0;
    ctrl_rd[CTRL_TX_EN]    = tx_en;
    ctrl_rd[CTRL_RX_EN]    = rx_en;
`ifdef SERIAL_LOOPBACK_EN
    ctrl_rd[CTRL_LOOPBACK] = loopback;
`endif
    rdata = '0;
    case (reg_addr)
      REG_RX_COUNT: rdata = 16'(rx_count);
      REG_RX_DATA:  rdata = rx_data;
      REG_TX_COUNT: rdata = 16'(tx_count);
      REG_TX_FREE:  rdata = 16'(tx_free);
      REG_STATUS:   rdata = status;
      REG_CTRL:     rdata = ctrl_rd;
      default:      rdata = '0;
    endcase
  end

  assign irq = (rx_count != '0) || rx_ovf || tx_ovf;

endmodule

`default_nettype wire

// File: rtl/mmio_serial_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_serial_ctrl: NCH-channel pulse-width serial peripheral for the MMIO window
// Rev 1.0 | optional feature macro: SERIAL_LOOPBACK_EN
// -----------------------------------------------------------------------------
`default_nettype none

module mmio_serial_ctrl
  import mmio_serial_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DEPTH    = 64,
  parameter int BIT_CLKS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bus_sel,
  input  logic           bus_we,
  input  logic [7:0]     bus_addr,
  input  logic [15:0]    bus_wdata,
  output logic [15:0]    bus_rdata,
  input  logic [NCH-1:0] ser_in,
  output logic [NCH-1:0] ser_out,
  output logic [NCH-1:0] irq
);

  logic [15:0] ch_rdata [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic ch_we;
    assign ch_we = bus_sel && bus_we && (bus_addr[7:4] == 4'(g));

    serial_channel #(
      .DEPTH    (DEPTH),
      .BIT_CLKS (BIT_CLKS)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (ch_we),
      .reg_addr (bus_addr[3:0]),
      .wdata    (bus_wdata),
      .rdata    (ch_rdata[g]),
      .ser_in   (ser_in[g]),
      .ser_out  (ser_out[g]),
      .irq      (irq[g])
    );
  end

  // Channel numbers at or above NCH match no iteration and read as zero.
  always_comb begin
    bus_rdata = '0;
    if (bus_sel) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus_addr[7:4] == 4'(i)) bus_rdata = ch_rdata[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_serial_ctrl: scoreboard bench for mmio_serial_ctrl (NCH=2, DEPTH=16, BIT_CLKS=16)
// Rev 1.0 | define SERIAL_LOOPBACK_EN to also exercise loopback
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mmio_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [7:0]  bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic [15:0] bus_rdata;
  logic [1:0]  ser_in = '0;
  logic [1:0]  ser_out;
  logic [1:0]  irq;

  mmio_serial_ctrl #(.NCH(2), .DEPTH(16), .BIT_CLKS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .ser_in    (ser_in),
    .ser_out   (ser_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] mask;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   exp_rise[$];
  int   exp_width[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic rd_req = 1'b0;
  logic final_chk = 1'b0;
  logic done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Monitor: pops the scoreboard on probe strobes and checks ch0 line pulses.
  initial begin
    exp_t        e;
    logic [15:0] act;
    logic        prev0;
    int          hw;
    int          r;
    prev0 = 1'b0;
    hw    = 0;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: probe with no expected value");
        end else begin
          e = sb.pop_front();
          case (e.kind)
            1:       act = 16'(irq);
            2:       act = 16'(ser_out);
            default: act = bus_rdata;
          endcase
          if ((act & e.mask) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%04h, expected 0x%04h", e.name, act & e.mask, e.exp);
          end
        end
      end
      if (ser_out[0] === 1'b1 && !prev0) begin
        n_checks++;
        hw = 1;
        if (exp_rise.size() == 0) begin
          n_fail++;
          $display("FAIL ch0_rise: actual rise at cycle %0d, expected no rise", cyc);
        end else begin
          r = exp_rise.pop_front();
          if (cyc != r) begin
            n_fail++;
            $display("FAIL ch0_rise: actual cycle %0d, expected cycle %0d", cyc, r);
          end
        end
      end else if (ser_out[0] === 1'b1) begin
        hw++;
      end else if (prev0) begin
        n_checks++;
        if (exp_width.size() == 0) begin
          n_fail++;
          $display("FAIL ch0_width: actual pulse of %0d clocks, expected none", hw);
        end else begin
          r = exp_width.pop_front();
          if (hw != r) begin
            n_fail++;
            $display("FAIL ch0_width: actual %0d clocks, expected %0d clocks", hw, r);
          end
        end
      end
      prev0 = (ser_out[0] === 1'b1);
      if (final_chk && !done) begin
        n_checks++;
        if (exp_rise.size() != 0 || exp_width.size() != 0 || sb.size() != 0) begin
          n_fail++;
          $display("FAIL leftover_expectations: actual %0d rises %0d widths %0d probes pending, expected 0",
                   exp_rise.size(), exp_width.size(), sb.size());
        end
        done = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk);
    #1;
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic probe(input int kind, input logic [15:0] mask, input logic [15:0] e,
                       input string nm, input logic [7:0] a, input logic sel);
    bus_sel = sel; bus_we = 1'b0; bus_addr = a;
    sb.push_back('{name: nm, kind: kind, mask: mask, exp: e});
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0; bus_sel = 1'b0;
  endtask

  task automatic expect_reg(input logic [7:0] a, input logic [15:0] e, input string nm);
    probe(0, 16'hFFFF, e, nm, a, 1'b1);
  endtask

  task automatic pulse(input int ch, input int w);
    ser_in[ch] = 1'b1;
    idle(w);
    ser_in[ch] = 1'b0;
  endtask

  initial begin
    int          widths[8];
    int          c0;
    logic [15:0] fill;
    widths = '{12, 4, 12, 4, 4, 12, 4, 12};
    fill   = 16'hA5C3;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    expect_reg(8'h09, 16'h0003, "ch0_ctrl_reset");
    expect_reg(8'h08, 16'h0000, "ch0_status_reset");
    expect_reg(8'h05, 16'd16,   "ch0_txfree_reset");
    expect_reg(8'h19, 16'h0003, "ch1_ctrl_reset");
    probe(2, 16'h0003, 16'h0000, "ser_out_reset", 8'h00, 1'b0);
    probe(1, 16'h0003, 16'h0000, "irq_reset", 8'h00, 1'b0);
    expect_reg(8'h29, 16'h0000, "bad_channel_reads_0");
    expect_reg(8'h03, 16'h0000, "undef_reg_reads_0");
    probe(0, 16'hFFFF, 16'h0000, "unselected_reads_0", 8'h09, 1'b0);

    bus_write(8'h07, 16'h00A5);
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      exp_rise.push_back(c0 + 1 + 16 * k);
      exp_width.push_back(widths[k]);
    end
    expect_reg(8'h04, 16'd8,    "ch0_txcount_after_push");
    expect_reg(8'h08, 16'h0004, "ch0_status_busy");
    expect_reg(8'h18, 16'h0000, "ch1_status_idle");
    probe(2, 16'h0002, 16'h0000, "ch1_ser_out_idle", 8'h00, 1'b0);
    idle(130);
    expect_reg(8'h04, 16'd0,    "ch0_txcount_drained");
    expect_reg(8'h08, 16'h0000, "ch0_status_done");

    pulse(1, 3);  idle(6);
    pulse(1, 10); idle(6);
    pulse(1, 1);  idle(6);
    expect_reg(8'h10, 16'd2,    "ch1_rxcount_2");
    expect_reg(8'h12, 16'h4000, "ch1_rxdata_01");
    probe(1, 16'h0003, 16'h0002, "irq1_set", 8'h00, 1'b0);
    bus_write(8'h11, 16'd2);
    expect_reg(8'h10, 16'd0,    "ch1_rxcount_popped");
    probe(1, 16'h0003, 16'h0000, "irq_all_clear", 8'h00, 1'b0);

    bus_write(8'h09, 16'h0002);
    bus_write(8'h06, 16'h1234);
    bus_write(8'h07, 16'h00FF);
    expect_reg(8'h04, 16'd16,   "ch0_txcount_full");
    expect_reg(8'h05, 16'd0,    "ch0_txfree_full");
    expect_reg(8'h08, 16'h0002, "ch0_tx_ovf");
    probe(1, 16'h0001, 16'h0001, "irq0_tx_ovf", 8'h00, 1'b0);
    bus_write(8'h08, 16'h0002);
    expect_reg(8'h08, 16'h0000, "ch0_tx_ovf_cleared");

    for (int i = 0; i < 16; i++) begin
      pulse(1, fill[15 - i] ? 10 : 3);
      idle(6);
    end
    expect_reg(8'h10, 16'd16,   "ch1_rx_full");
    expect_reg(8'h12, 16'hA5C3, "ch1_rxdata_full");
    pulse(1, 10); idle(6);
    expect_reg(8'h10, 16'd16,   "ch1_rx_full_after_ovf");
    expect_reg(8'h18, 16'h0009, "ch1_rx_ovf_set");
    bus_write(8'h18, 16'h0001);
    expect_reg(8'h18, 16'h0008, "ch1_rx_ovf_cleared");
    pulse(1, 10);
    idle(2);
    bus_write(8'h11, 16'd1);
    expect_reg(8'h10, 16'd16,   "ch1_pop_append_same_cycle");
    expect_reg(8'h18, 16'h0008, "ch1_no_ovf_on_pop_append");
    expect_reg(8'h12, 16'h4B87, "ch1_rxdata_shifted");
    bus_write(8'h11, 16'd16);
    expect_reg(8'h10, 16'd0,    "ch1_rx_emptied");

    bus_write(8'h19, 16'h0007);
`ifdef SERIAL_LOOPBACK_EN
    expect_reg(8'h19, 16'h0007, "ch1_ctrl_loopback");
    bus_write(8'h17, 16'h003C);
    idle(131);
    expect_reg(8'h12, 16'h3C00, "ch1_loopback_rxdata");
    expect_reg(8'h10, 16'd8,    "ch1_loopback_rxcount");
`else
    expect_reg(8'h19, 16'h0003, "ch1_ctrl_bit2_ignored");
`endif

    final_chk = 1'b1;
    for (int i = 0; i < 10 && !done; i++) @(posedge clk);
    if (!done) begin
      $display("FAIL final_check: actual monitor not finished, expected finished");
      $fatal(1, "monitor stalled");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
